// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared types and constants for the RV32I front end.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam int          ROM_BYTES    = 4096;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_gen
// Description : Next-PC mux (sequential / redirect) with ROM-window legality.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_gen #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter int                    ROM_BYTES    = 4096
) (
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    output logic [DATA_WIDTH-1:0] next_pc,
    output logic                  next_illegal
);
    import riscv_pkg::*;

    localparam logic [DATA_WIDTH-1:0] c_last_addr =
        RESET_VECTOR + DATA_WIDTH'(ROM_BYTES) - DATA_WIDTH'(4);

    // PC+4 wraps modulo 2^W; a wrapped address falls below the window and is illegal.
    assign next_pc      = redirect ? redirect_target : pc + DATA_WIDTH'(4);
    assign next_illegal = (next_pc[1:0] != 2'b00) ||
                          (next_pc < RESET_VECTOR)  ||
                          (next_pc > c_last_addr);

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV32I instruction fetch: PC register, IF/ID register, fault FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = riscv_pkg::RESET_VECTOR,
    parameter int                    ROM_BYTES    = riscv_pkg::ROM_BYTES,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = riscv_pkg::NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    input  logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] id_instr,
    output logic [DATA_WIDTH-1:0] id_pc,
    output logic [DATA_WIDTH-1:0] id_pc_plus4,
    output logic                  id_valid,
    output logic                  fetch_fault
);
    import riscv_pkg::*;

    fetch_state_t          r_state;
    fetch_state_t          w_state_next;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_id_instr;
    logic [DATA_WIDTH-1:0] r_id_pc;
    logic                  r_id_valid;
    logic [DATA_WIDTH-1:0] w_next_pc;
    logic                  w_next_illegal;
    logic                  w_capture;
    logic                  w_flush;
    logic                  w_pc_load;

    fetch_pc_gen #(
        .DATA_WIDTH   (DATA_WIDTH),
        .RESET_VECTOR (RESET_VECTOR),
        .ROM_BYTES    (ROM_BYTES)
    ) u_pc_gen (
        .pc              (r_pc),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .next_pc         (w_next_pc),
        .next_illegal    (w_next_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Redirect wins over stall; an illegal next address parks the stage in FAULT
    // while a sequential fetch still captures the last in-window word.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_flush      = 1'b0;
        w_pc_load    = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_next = RUN;
            end
            RUN: begin
                if (redirect || !stall) begin
                    if (w_next_illegal) begin
                        w_state_next = FAULT;
                    end else begin
                        w_pc_load = 1'b1;
                    end
                end
                if (redirect) begin
                    w_flush = 1'b1;
                end else if (!stall) begin
                    w_capture = 1'b1;
                end
            end
            FAULT: begin
                w_flush = 1'b1;
            end
            default: begin
                w_state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_VECTOR;
            r_id_instr <= NOP_INSTR;
            r_id_pc    <= RESET_VECTOR;
            r_id_valid <= 1'b0;
        end else begin
            if (w_pc_load) begin
                r_pc <= w_next_pc;
            end
            if (w_capture) begin
                r_id_instr <= instr;
                r_id_pc    <= r_pc;
                r_id_valid <= 1'b1;
            end else if (w_flush) begin
                r_id_instr <= NOP_INSTR;
                r_id_valid <= 1'b0;
            end
        end
    end

    assign PC          = r_pc;
    assign id_instr    = r_id_instr;
    assign id_pc       = r_id_pc;
    assign id_pc_plus4 = r_id_pc + DATA_WIDTH'(4);
    assign id_valid    = r_id_valid;
    assign fetch_fault = (r_state == FAULT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_rv   = 32'hBFC0_0000;
    localparam logic [31:0] c_nop  = 32'h0000_0013;
    localparam logic [31:0] c_last = 32'hBFC0_0FFC;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] instr;
    logic [31:0] PC;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .instr           (instr),
        .PC              (PC),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_pc_plus4     (id_pc_plus4),
        .id_valid        (id_valid),
        .fetch_fault     (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a >= c_rv) && (a <= c_last);
    endfunction

    assign instr = rom(PC);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = boot cycle pending, 1 = fetching, 2 = faulted.
    int          m_mode;
    logic [31:0] m_pc, m_id_instr, m_id_pc;
    logic        m_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_pc = c_rv; m_id_instr = c_nop; m_id_pc = c_rv; m_valid = 1'b0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 2) begin
            m_valid = 1'b0; m_id_instr = c_nop;
        end else if (redirect) begin
            m_valid = 1'b0; m_id_instr = c_nop;
            if (legal(redirect_target)) m_pc = redirect_target;
            else m_mode = 2;
        end else if (!stall) begin
            m_id_instr = rom(m_pc); m_id_pc = m_pc; m_valid = 1'b1;
            if (legal(m_pc + 32'd4)) m_pc = m_pc + 32'd4;
            else m_mode = 2;
        end
    end

    always @(negedge clk) begin
        chk("model_pc", PC, m_pc);
        chk("model_id_instr", id_instr, m_id_instr);
        chk("model_id_pc", id_pc, m_id_pc);
        chk("model_id_pc_plus4", id_pc_plus4, m_id_pc + 32'd4);
        chk("model_id_valid", {31'd0, id_valid}, {31'd0, m_valid});
        chk("model_fault", {31'd0, fetch_fault}, {31'd0, m_mode == 2});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; redirect = 1'b0; stall = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
        repeat (2) step();
        chk("rst_pc", PC, c_rv);
        chk("rst_id_instr", id_instr, c_nop);
        chk("rst_id_pc_plus4", id_pc_plus4, 32'hBFC0_0004);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);

        // Boot then sequential fetch
        rst_n = 1'b1;
        step();
        chk("boot_pc", PC, 32'hBFC0_0000);
        chk("boot_valid", {31'd0, id_valid}, 32'd0);
        step();
        chk("seq1_id_pc", id_pc, 32'hBFC0_0000);
        chk("seq1_id_instr", id_instr, rom(32'hBFC0_0000));
        chk("seq1_valid", {31'd0, id_valid}, 32'd1);
        chk("seq1_pc", PC, 32'hBFC0_0004);
        step();
        chk("seq2_id_pc", id_pc, 32'hBFC0_0004);
        chk("seq2_pc", PC, 32'hBFC0_0008);

        // Redirect with one-bubble flush
        redirect = 1'b1; redirect_target = 32'hBFC0_0010;
        step();
        chk("redir0_pc", PC, 32'hBFC0_0010);
        redirect_target = 32'hBFC0_0100;
        step();
        chk("redir_pc", PC, 32'hBFC0_0100);
        chk("redir_valid", {31'd0, id_valid}, 32'd0);
        chk("redir_nop", id_instr, c_nop);
        redirect = 1'b0;
        step();
        chk("redir_id_pc", id_pc, 32'hBFC0_0100);
        chk("redir_plus4", id_pc_plus4, 32'hBFC0_0104);
        chk("redir_valid1", {31'd0, id_valid}, 32'd1);

        // Stall holds everything; redirect overrides stall
        redirect = 1'b1; redirect_target = 32'hBFC0_0020;
        step();
        redirect = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", PC, 32'hBFC0_0020);
            chk("stall_id_pc", id_pc, 32'hBFC0_0100);
            chk("stall_valid", {31'd0, id_valid}, 32'd0);
        end
        redirect = 1'b1; redirect_target = 32'hBFC0_0040;
        step();
        chk("stall_redir_pc", PC, 32'hBFC0_0040);
        chk("stall_redir_valid", {31'd0, id_valid}, 32'd0);

        // Misaligned redirect traps and is sticky
        stall = 1'b0; redirect_target = 32'hBFC0_0102;
        step();
        chk("misal_fault", {31'd0, fetch_fault}, 32'd1);
        chk("misal_pc", PC, 32'hBFC0_0040);
        for (int i = 0; i < 5; i++) begin
            redirect = i[0]; stall = ~i[0]; redirect_target = 32'hBFC0_0200;
            step();
            chk("sticky_fault", {31'd0, fetch_fault}, 32'd1);
            chk("sticky_pc", PC, 32'hBFC0_0040);
            chk("sticky_valid", {31'd0, id_valid}, 32'd0);
        end

        // Out-of-window redirect
        do_reset();
        redirect = 1'b1; redirect_target = 32'h0000_1000;
        step();
        chk("oow_fault", {31'd0, fetch_fault}, 32'd1);
        chk("oow_pc", PC, 32'hBFC0_0000);
        chk("oow_valid", {31'd0, id_valid}, 32'd0);

        // Run off the end of the window
        do_reset();
        redirect = 1'b1; redirect_target = 32'hBFC0_0FF0;
        step();
        redirect = 1'b0;
        repeat (3) step();
        chk("end_pc", PC, 32'hBFC0_0FFC);
        chk("end_fault0", {31'd0, fetch_fault}, 32'd0);
        step();
        chk("end_id_pc", id_pc, 32'hBFC0_0FFC);
        chk("end_id_instr", id_instr, rom(32'hBFC0_0FFC));
        chk("end_valid", {31'd0, id_valid}, 32'd1);
        chk("end_fault", {31'd0, fetch_fault}, 32'd1);
        chk("end_pc_hold", PC, 32'hBFC0_0FFC);
        step();
        chk("end_valid_clr", {31'd0, id_valid}, 32'd0);
        chk("end_nop", id_instr, c_nop);

        // Asynchronous reset from FAULT, then from RUN
        @(posedge clk); #2 rst_n = 1'b0; #1;
        chk("arst_f_pc", PC, c_rv);
        chk("arst_f_fault", {31'd0, fetch_fault}, 32'd0);
        chk("arst_f_valid", {31'd0, id_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("reboot_pc", PC, c_rv);
        chk("reboot_valid", {31'd0, id_valid}, 32'd0);
        step();
        chk("reboot_id_pc", id_pc, c_rv);
        chk("reboot_valid1", {31'd0, id_valid}, 32'd1);
        step();
        @(posedge clk); #2 rst_n = 1'b0; #1;
        chk("arst_r_pc", PC, c_rv);
        chk("arst_r_valid", {31'd0, id_valid}, 32'd0);
        chk("arst_r_id_pc", id_pc, c_rv);
        step();
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            int sel;
            stall    = ($urandom % 10) < 3;
            redirect = ($urandom % 10) == 0;
            sel = $urandom % 10;
            case (sel)
                0:       redirect_target = c_rv + 32'($urandom_range(1, 3));
                1:       redirect_target = {$urandom} & 32'hFFFF_FFFC;
                2:       redirect_target = c_rv + 32'h1000;
                3, 4:    redirect_target = c_last - 32'(4 * $urandom_range(0, 6));
                default: redirect_target = c_rv + 32'(4 * $urandom_range(0, 1023));
            endcase
            if ((m_mode == 2 && ($urandom % 4) == 0) || ($urandom % 400) == 0) begin
                rst_n = 1'b0;
            end else begin
                rst_n = 1'b1;
            end
            step();
        end
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
